instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Instruction sequencer that drives the 9-bit processor's `DIN`/`Run`/`Done` handshake from a 256-word instruction memory, replacing the hand-written stimulus tasks with autonomous fetch-and-issue. It sits between the instruction RAM (`mem_instr`) and the processor core's `DIN`/`Run` inputs. It sequences two-word move-immediate instructions, stops on a HALT opcode or on request, and flags a hung processor with a watchdog.

## Interface
Parameters:
- `AW`, 8: instruction address width; memory depth is 2^AW.
- `IMM_OP`, 3'b001: opcode (`[8:6]`) that carries a second immediate word.
- `HALT_OP`, 3'b111: opcode consumed by the sequencer and never issued.
- `TIMEOUT`, 64: maximum cycles spent waiting for `Done` before error.

Ports:
- `Clock`  in  1  rising-edge clock.
- `Reset`  in  1  asynchronous, active-high reset.
- `Start`  in  1  one-cycle pulse that begins execution at `StartAddr`.
- `StartAddr`  in  AW  first instruction address.
- `Stop`  in  1  level or pulse; requests stop after the current instruction completes.
- `imem_addr`  out  AW  instruction memory read address.
- `imem_rdata`  in  9  read data, valid the cycle after `imem_addr` is presented (synchronous read).
- `DIN`  out  9  instruction or immediate word to the processor.
- `Run`  out  1  instruction-valid strobe to the processor.
- `Done`  in  1  processor instruction-complete.
- `pc`  out  AW  address of the next word to fetch.
- `Busy`  out  1  high in any state except IDLE, HALTED and ERROR.
- `Halted`  out  1  high in HALTED.
- `Error`  out  1  high in ERROR.
- `instr_count`  out  16  completed instructions, saturating.

## Operation
- States: IDLE, FETCH, ISSUE, IMM, WAIT, HALTED, ERROR.
- `imem_addr` = `pc` (combinational). `DIN` = `imem_rdata` in ISSUE and IMM, else 0. `Run` = 1 only in ISSUE when `imem_rdata[8:6]` != `HALT_OP`.
- IDLE, HALTED and ERROR on `Start`: `pc` <= `StartAddr`, `instr_count` <= 0, stop flag cleared, go to FETCH.
- FETCH: `pc` <= `pc`+1, go to ISSUE.
- ISSUE: if the opcode is `HALT_OP`, go to HALTED and issue nothing. If the opcode is `IMM_OP`, `pc` <= `pc`+1 and go to IMM. Otherwise go to WAIT.
- IMM: drives the immediate word with `Run`=0. If `Done`=1, complete and exit (see below). Otherwise go to WAIT.
- WAIT: the watchdog counts up from 0, starting at entry. When `Done`=1, complete and exit. When the watchdog reaches `TIMEOUT`-1 with `Done`=0, go to ERROR.
- Completion: `instr_count`++ (saturates at 16'hFFFF). Next state is IDLE if the stop flag or `Stop` is set, else FETCH.
- The stop flag is set by `Stop`=1 in any Busy state and cleared on `Start`.
- `Start` in a Busy state is ignored.
- `pc` wraps from 2^AW-1 to 0 with no flag. An immediate word at the wrapped address is fetched normally.
- `Done` seen in FETCH or ISSUE is ignored; the processor cannot complete in those states.

## Timing
- Reset values: state IDLE, `pc`=0, `instr_count`=0, stop flag=0, watchdog=0. Outputs `DIN`=0, `Run`=0, `Busy`=0, `Halted`=0, `Error`=0, `imem_addr`=0.
- Reset mid-instruction aborts immediately; `Run` drops asynchronously.
- Issue latency: `Start` at edge N puts state FETCH in cycle N+1 and `Run`=1 with the instruction in cycle N+2.
- For an `IMM_OP` instruction, the immediate is on `DIN` the cycle immediately after the `Run` cycle.
- Back-to-back instructions: `Done` sampled at edge M gives FETCH in cycle M+1 and the next `Run` in cycle M+2.
- `Run` is never high for two consecutive cycles.

## Test plan
- Program `[0]=001000000, [1]=000000111, [2]=111000000`, then `Start` with `StartAddr`=0. Required: `Run` for one cycle with `DIN`=9'h040, next cycle `DIN`=9'h007 and `Run`=0. After `Done`: `instr_count`=1, `Halted`=1, `pc`=3.
- Program `[5]=000100000, [6]=100011010, [7]=111000000`, `Start` at 5, processor answering `Done` 3 cycles after each `Run`. Required: two `Run` pulses exactly 2 cycles after each `Done`, then `Halted`, `instr_count`=2.
- Program a non-halting loop; assert `Stop` during WAIT of the third instruction. Required: IDLE right after that `Done`, `instr_count`=3, `Busy`=0, no further `Run`.
- Withhold `Done` after the first `Run` (TIMEOUT=64). Required: `Error`=1 64 cycles after entering WAIT, `Busy`=0. A subsequent `Start` clears `Error` and restarts.
- Program `[255]=001001000, [0]=000001001`, `Start` at 255. Required: `pc` wraps, immediate 9'h009 is driven, `pc`=1 afterwards.
- Assert `Reset` during IMM. Required: all outputs return to reset values asynchronously. `Start` pulsed while `Busy` has no effect.

Source files
------------

// File: rtl/instr_sequencer.sv
// Autonomous fetch-and-issue sequencer for the 9-bit processor: reads instruction memory,
// drives the DIN/Run handshake, tracks completions and watches for a hung core.
module instr_sequencer #(
  parameter int         AW      = 8,
  parameter logic [2:0] IMM_OP  = 3'b001,
  parameter logic [2:0] HALT_OP = 3'b111,
  parameter int         TIMEOUT = 64
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Start,
  input  logic [AW-1:0] StartAddr,
  input  logic          Stop,
  output logic [AW-1:0] imem_addr,
  input  logic [8:0]    imem_rdata,
  output logic [8:0]    DIN,
  output logic          Run,
  input  logic          Done,
  output logic [AW-1:0] pc,
  output logic          Busy,
  output logic          Halted,
  output logic          Error,
  output logic [15:0]   instr_count
);

  localparam int WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_IMM, S_WAIT, S_HALTED, S_ERROR
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            stop_q, stop_d;
  logic [WDW-1:0]  wdog_q, wdog_d;
  logic            complete;
  logic            busy;
  logic [2:0]      opcode;

  assign opcode = imem_rdata[8:6];
  assign busy   = (state_q == S_FETCH) || (state_q == S_ISSUE) ||
                  (state_q == S_IMM)   || (state_q == S_WAIT);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    stop_d   = stop_q;
    wdog_d   = '0;
    complete = 1'b0;

    if (busy && Stop) stop_d = 1'b1;

    case (state_q)
      S_IDLE, S_HALTED, S_ERROR: begin
        if (Start) begin
          pc_d    = StartAddr;
          cnt_d   = '0;
          stop_d  = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        pc_d    = pc_q + AW'(1);
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (opcode == HALT_OP) begin
          state_d = S_HALTED;
        end else if (opcode == IMM_OP) begin
          pc_d    = pc_q + AW'(1);
          state_d = S_IMM;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_IMM: begin
        if (Done) complete = 1'b1;
        else      state_d  = S_WAIT;
      end
      S_WAIT: begin
        // Watchdog holds 0 on the entry cycle; timeout fires on the TIMEOUT-th waiting cycle.
        if (Done) begin
          complete = 1'b1;
        end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
          state_d = S_ERROR;
        end else begin
          wdog_d = wdog_q + WDW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (complete) begin
      cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
      state_d = (stop_q || Stop) ? S_IDLE : S_FETCH;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      stop_q  <= 1'b0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      stop_q  <= stop_d;
      wdog_q  <= wdog_d;
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign DIN         = ((state_q == S_ISSUE) || (state_q == S_IMM)) ? imem_rdata : 9'd0;
  assign Run         = (state_q == S_ISSUE) && (opcode != HALT_OP);
  assign Busy        = busy;
  assign Halted      = (state_q == S_HALTED);
  assign Error       = (state_q == S_ERROR);
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: expected DIN words are queued with each program,
// a negedge monitor pops them on every Run and on the immediate cycle that follows.
module tb_instr_sequencer;

  localparam int AW     = 8;
  localparam int W_RUN  = 0;
  localparam int W_HALT = 1;
  localparam int W_IDLE = 2;

  logic          Clock = 1'b0;
  logic          Reset, Start, Stop, Done;
  logic [AW-1:0] StartAddr, imem_addr, pc;
  logic [8:0]    imem_rdata, DIN;
  logic          Run, Busy, Halted, Error;
  logic [15:0]   instr_count;

  logic [8:0] mem [256];
  logic [8:0] expQ [$];
  int assertCount = 0;
  int failCount   = 0;
  int doneDelay   = 0;
  int doneTimer   = 0;
  int cycleNum    = 0;
  int t0;
  logic prevRun = 1'b0;
  logic prevImm = 1'b0;

  instr_sequencer #(.AW(AW), .IMM_OP(3'b001), .HALT_OP(3'b111), .TIMEOUT(64)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .StartAddr(StartAddr), .Stop(Stop),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .DIN(DIN), .Run(Run), .Done(Done),
    .pc(pc), .Busy(Busy), .Halted(Halted), .Error(Error), .instr_count(instr_count)
  );

  always #5 Clock = ~Clock;

  // Synchronous-read instruction RAM plus a free-running cycle counter
  always @(posedge Clock) begin
    imem_rdata <= mem[imem_addr];
    cycleNum   <= cycleNum + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual %0h, required %0h", name, actual, expected);
    end
  endtask

  task automatic popCheck(input string name);
    if (expQ.size() == 0) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL %s: actual DIN %0h, required no word", name, DIN);
    end else begin
      checkOutput(name, DIN, expQ.pop_front());
    end
  endtask

  // Processor model: pulses Done doneDelay cycles after each Run (0 = never answers)
  initial begin
    Done = 1'b0;
    forever begin
      @(negedge Clock);
      if (Reset) begin
        doneTimer = 0;
        Done = 1'b0;
      end else if (Run) begin
        doneTimer = doneDelay;
        Done = 1'b0;
      end else if (doneTimer > 0) begin
        doneTimer--;
        Done = (doneTimer == 0);
      end else begin
        Done = 1'b0;
      end
    end
  end

  // Monitor: every issued word and every following immediate is scored against the queue
  initial begin
    forever begin
      @(negedge Clock);
      if (Reset) begin
        prevRun = 1'b0;
        prevImm = 1'b0;
      end else begin
        if (prevImm) begin
          popCheck("imm_din");
          checkOutput("imm_run_low", Run, 0);
        end
        if (Run) begin
          checkOutput("run_single_cycle", prevRun, 0);
          popCheck("issue_din");
          prevImm = (DIN[8:6] == 3'b001);
        end else begin
          prevImm = 1'b0;
        end
        prevRun = Run;
      end
    end
  end

  task automatic applyStimulus(input logic [AW-1:0] addr);
    @(negedge Clock);
    StartAddr = addr;
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  task automatic waitSignal(input string name, input int which, input int budget);
    int n = 0;
    logic hit = 1'b0;
    while (!hit && n < budget) begin
      @(negedge Clock);
      n++;
      case (which)
        W_RUN:   hit = Run;
        W_HALT:  hit = Halted;
        default: hit = !Busy;
      endcase
    end
    checkOutput({"wait_", name}, hit, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: actual running, required finished");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  initial begin
    Reset = 1'b1; Start = 1'b0; Stop = 1'b0; StartAddr = '0;
    for (int i = 0; i < 256; i++) mem[i] = 9'h1C0;
    #1;
    checkOutput("rst_run", Run, 0);
    checkOutput("rst_din", DIN, 0);
    checkOutput("rst_busy", Busy, 0);
    checkOutput("rst_halted", Halted, 0);
    checkOutput("rst_error", Error, 0);
    checkOutput("rst_pc", pc, 0);
    checkOutput("rst_imem_addr", imem_addr, 0);
    checkOutput("rst_count", instr_count, 0);
    repeat (2) @(negedge Clock);
    Reset = 1'b0;

    // Immediate instruction followed by HALT
    mem[0] = 9'h040; mem[1] = 9'h007; mem[2] = 9'h1C0;
    doneDelay = 3;
    expQ.push_back(9'h040); expQ.push_back(9'h007);
    applyStimulus(8'd0);
    checkOutput("t1_fetch_busy", Busy, 1);
    checkOutput("t1_fetch_run", Run, 0);
    @(negedge Clock);
    checkOutput("t1_issue_latency", Run, 1);
    waitSignal("t1_halt", W_HALT, 40);
    checkOutput("t1_count", instr_count, 1);
    checkOutput("t1_pc", pc, 3);
    checkOutput("t1_busy", Busy, 0);

    // Two plain instructions, Run exactly two cycles after each Done
    mem[5] = 9'h020; mem[6] = 9'h11A; mem[7] = 9'h1C0;
    expQ.push_back(9'h020); expQ.push_back(9'h11A);
    applyStimulus(8'd5);
    waitSignal("t2_run1", W_RUN, 10);
    t0 = cycleNum;
    waitSignal("t2_run2", W_RUN, 20);
    checkOutput("t2_run_spacing", cycleNum - t0, 5);
    waitSignal("t2_halt", W_HALT, 20);
    checkOutput("t2_count", instr_count, 2);
    checkOutput("t2_pc", pc, 8);

    // Stop requested during WAIT of the third instruction of a non-halting run
    for (int i = 0; i < 8; i++) mem[16 + i] = 9'(i + 1);
    expQ.push_back(9'h001); expQ.push_back(9'h002); expQ.push_back(9'h003);
    applyStimulus(8'd16);
    for (int k = 0; k < 3; k++) waitSignal("t3_run", W_RUN, 20);
    @(negedge Clock);
    Stop = 1'b1;
    @(negedge Clock);
    Stop = 1'b0;
    waitSignal("t3_idle", W_IDLE, 20);
    checkOutput("t3_count", instr_count, 3);
    checkOutput("t3_pc", pc, 19);
    checkOutput("t3_halted", Halted, 0);
    repeat (10) @(negedge Clock);
    checkOutput("t3_still_idle", Busy, 0);

    // Watchdog: Done withheld, Error on the 65th cycle after Run
    mem[32] = 9'h005;
    doneDelay = 0;
    expQ.push_back(9'h005);
    applyStimulus(8'd32);
    waitSignal("t4_run", W_RUN, 10);
    repeat (64) @(negedge Clock);
    checkOutput("t4_error_early", Error, 0);
    checkOutput("t4_busy_early", Busy, 1);
    @(negedge Clock);
    checkOutput("t4_error", Error, 1);
    checkOutput("t4_busy", Busy, 0);
    applyStimulus(8'd40);
    checkOutput("t4_error_cleared", Error, 0);
    checkOutput("t4_restart_busy", Busy, 1);
    waitSignal("t4_halt", W_HALT, 20);
    checkOutput("t4_count", instr_count, 0);

    // Address wrap with the immediate word at address 0
    mem[255] = 9'h048; mem[0] = 9'h009; mem[1] = 9'h1C0;
    doneDelay = 3;
    expQ.push_back(9'h048); expQ.push_back(9'h009);
    applyStimulus(8'd255);
    waitSignal("t5_run", W_RUN, 10);
    checkOutput("t5_pc_wrapped", pc, 0);
    @(negedge Clock);
    checkOutput("t5_pc_after_imm", pc, 1);
    waitSignal("t5_halt", W_HALT, 20);
    checkOutput("t5_count", instr_count, 1);
    checkOutput("t5_pc_final", pc, 2);

    // Asynchronous reset in the middle of an immediate transfer
    mem[48] = 9'h043; mem[49] = 9'h010; mem[50] = 9'h1C0;
    expQ.push_back(9'h043); expQ.push_back(9'h010);
    applyStimulus(8'd48);
    waitSignal("t6_run", W_RUN, 10);
    @(negedge Clock);
    #1 Reset = 1'b1;
    #1;
    checkOutput("t6_run", Run, 0);
    checkOutput("t6_din", DIN, 0);
    checkOutput("t6_busy", Busy, 0);
    checkOutput("t6_pc", pc, 0);
    checkOutput("t6_imem_addr", imem_addr, 0);
    checkOutput("t6_count", instr_count, 0);
    checkOutput("t6_halted", Halted, 0);
    checkOutput("t6_error", Error, 0);
    @(negedge Clock);
    #1 Reset = 1'b0;

    // Start pulsed while Busy must not redirect the sequencer
    mem[56] = 9'h001; mem[57] = 9'h002; mem[58] = 9'h1C0; mem[60] = 9'h1C0;
    expQ.push_back(9'h001); expQ.push_back(9'h002);
    applyStimulus(8'd56);
    waitSignal("t7_run", W_RUN, 10);
    @(negedge Clock);
    StartAddr = 8'd60;
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    waitSignal("t7_halt", W_HALT, 40);
    checkOutput("t7_count", instr_count, 2);
    checkOutput("t7_pc", pc, 59);

    checkOutput("queue_drained", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
